// File: rtl/window_operand_feeder.sv
// ============================================================================
// window_operand_feeder
//
// Purpose:
//   Pairs each incoming float32 sample with the window coefficient for its
//   position in the analysis frame. The pair is then presented on two
//   independent AXI-Stream operand channels that feed a float32 multiplier.
//   Channel a carries the sample and channel b carries the coefficient.
//   The coefficient RAM can be rewritten at any time through a simple write
//   port. Reset does not clear the RAM.
//
// Ports:
//   aclk, aresetn                  rising-edge clock, async active-low reset
//   s_axis_t{valid,ready,data,last} input sample stream (32-bit float)
//   coef_wr_{en,addr,data}         coefficient RAM write port
//   m_axis_a_t{valid,ready,data,last} sample operand output
//   m_axis_b_t{valid,ready,data,last} coefficient operand output
//   sample_idx                     index of the next sample to be accepted
//   frame_done                     1-cycle pulse once the last pair is consumed
//   frame_err                      sticky flag: input tlast disagreed with index
// ============================================================================
module window_operand_feeder #(
    parameter int FRAME_LEN = 256,
    parameter int IDX_W     = 8
) (
    input  logic             aclk,
    input  logic             aresetn,

    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic [31:0]      s_axis_tdata,
    input  logic             s_axis_tlast,

    input  logic             coef_wr_en,
    input  logic [IDX_W-1:0] coef_wr_addr,
    input  logic [31:0]      coef_wr_data,

    output logic             m_axis_a_tvalid,
    input  logic             m_axis_a_tready,
    output logic [31:0]      m_axis_a_tdata,
    output logic             m_axis_a_tlast,

    output logic             m_axis_b_tvalid,
    input  logic             m_axis_b_tready,
    output logic [31:0]      m_axis_b_tdata,
    output logic             m_axis_b_tlast,

    output logic [IDX_W-1:0] sample_idx,
    output logic             frame_done,
    output logic             frame_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    logic [31:0] coef_ram [FRAME_LEN];

    logic a_free;
    logic b_free;
    logic accept;
    logic a_hs;
    logic b_hs;
    logic idx_at_end;
    logic last_flag;

    // A channel is free when it is empty or is being drained this cycle.
    // A new sample is taken only when both halves of the pair can move.
    // While reset is held, the block never reports itself ready.
    assign a_free        = !m_axis_a_tvalid | m_axis_a_tready;
    assign b_free        = !m_axis_b_tvalid | m_axis_b_tready;
    assign s_axis_tready = aresetn & a_free & b_free;
    assign accept        = s_axis_tvalid & s_axis_tready;

    assign a_hs       = m_axis_a_tvalid & m_axis_a_tready;
    assign b_hs       = m_axis_b_tvalid & m_axis_b_tready;
    assign idx_at_end = (sample_idx == LAST_IDX);
    assign last_flag  = s_axis_tlast | idx_at_end;

    // Coefficient RAM write port. It has no reset, so the window survives a
    // pipeline reset.
    always_ff @(posedge aclk) begin
        if (coef_wr_en) begin
            coef_ram[coef_wr_addr] <= coef_wr_data;
        end
    end

    // Sample operand channel (a). It holds its data until it handshakes. It
    // is reloaded whenever a new pair is accepted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_a_tvalid <= 1'b0;
            m_axis_a_tdata  <= '0;
            m_axis_a_tlast  <= 1'b0;
        end else if (accept) begin
            m_axis_a_tvalid <= 1'b1;
            m_axis_a_tdata  <= s_axis_tdata;
            m_axis_a_tlast  <= last_flag;
        end else if (m_axis_a_tready) begin
            m_axis_a_tvalid <= 1'b0;
        end
    end

    // Coefficient operand channel (b). The RAM read uses the pre-edge
    // contents. A write to the same address in the same cycle therefore
    // only affects later frames.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_b_tvalid <= 1'b0;
            m_axis_b_tdata  <= '0;
            m_axis_b_tlast  <= 1'b0;
        end else if (accept) begin
            m_axis_b_tvalid <= 1'b1;
            m_axis_b_tdata  <= coef_ram[sample_idx];
            m_axis_b_tlast  <= last_flag;
        end else if (m_axis_b_tready) begin
            m_axis_b_tvalid <= 1'b0;
        end
    end

    // Frame position tracking. An early tlast restarts the frame, exactly
    // like a natural wrap. Any disagreement between tlast and the index is
    // latched as an error.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sample_idx <= '0;
            frame_err  <= 1'b0;
        end else if (accept) begin
            sample_idx <= last_flag ? '0 : sample_idx + 1'b1;
            if (s_axis_tlast != idx_at_end) begin
                frame_err <= 1'b1;
            end
        end
    end

    // The frame is done when the later half of a tlast pair handshakes.
    // A channel that is not valid here was already drained for this pair,
    // because no new pair can load until both halves are free.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= (a_hs & m_axis_a_tlast & (!m_axis_b_tvalid | b_hs)) |
                          (b_hs & m_axis_b_tlast & (!m_axis_a_tvalid | a_hs));
        end
    end

endmodule

// File: tb/tb_window_operand_feeder.sv
// ============================================================================
// tb_window_operand_feeder
//
// Directed self-checking bench for window_operand_feeder. Inputs are driven
// and outputs sampled on the falling clock edge. The bench keeps its own copy
// of the coefficient table to derive expected operand values.
// ============================================================================
module tb_window_operand_feeder;

    localparam int FRAME_LEN = 256;
    localparam int IDX_W     = 8;

    logic             aclk;
    logic             aresetn;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [31:0]      s_axis_tdata;
    logic             s_axis_tlast;
    logic             coef_wr_en;
    logic [IDX_W-1:0] coef_wr_addr;
    logic [31:0]      coef_wr_data;
    logic             m_axis_a_tvalid;
    logic             m_axis_a_tready;
    logic [31:0]      m_axis_a_tdata;
    logic             m_axis_a_tlast;
    logic             m_axis_b_tvalid;
    logic             m_axis_b_tready;
    logic [31:0]      m_axis_b_tdata;
    logic             m_axis_b_tlast;
    logic [IDX_W-1:0] sample_idx;
    logic             frame_done;
    logic             frame_err;

    logic [31:0] exp_coef [FRAME_LEN];
    int checks;
    int errors;
    int done_cnt;

    window_operand_feeder #(.FRAME_LEN(FRAME_LEN), .IDX_W(IDX_W)) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tlast    (s_axis_tlast),
        .coef_wr_en      (coef_wr_en),
        .coef_wr_addr    (coef_wr_addr),
        .coef_wr_data    (coef_wr_data),
        .m_axis_a_tvalid (m_axis_a_tvalid),
        .m_axis_a_tready (m_axis_a_tready),
        .m_axis_a_tdata  (m_axis_a_tdata),
        .m_axis_a_tlast  (m_axis_a_tlast),
        .m_axis_b_tvalid (m_axis_b_tvalid),
        .m_axis_b_tready (m_axis_b_tready),
        .m_axis_b_tdata  (m_axis_b_tdata),
        .m_axis_b_tlast  (m_axis_b_tlast),
        .sample_idx      (sample_idx),
        .frame_done      (frame_done),
        .frame_err       (frame_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Single comparison point: counts the check and reports any difference.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Streams n back-to-back samples starting at frame index first_idx, with
    // both readies high. s_axis_tlast is asserted on offset tlast_pos (-1 for
    // none). Every pair is checked one cycle after it is driven. frame_done
    // pulses are counted until two cycles after the final pair.
    task automatic apply_stimulus(input int first_idx, input int n, input int tlast_pos,
                                  input logic [31:0] base, output int pulses);
        int idx;
        logic exp_last;
        pulses = 0;
        for (int k = 0; k <= n; k++) begin
            @(negedge aclk);
            if (frame_done) pulses++;
            if (k > 0) begin
                idx      = (first_idx + k - 1) % FRAME_LEN;
                exp_last = ((k - 1) == tlast_pos) || (idx == FRAME_LEN - 1);
                check_output($sformatf("a_tvalid[%0d]", idx), {31'd0, m_axis_a_tvalid}, 32'd1);
                check_output($sformatf("a_tdata[%0d]", idx), m_axis_a_tdata, base + 32'(k - 1));
                check_output($sformatf("b_tdata[%0d]", idx), m_axis_b_tdata, exp_coef[idx]);
                check_output($sformatf("a_tlast[%0d]", idx), {31'd0, m_axis_a_tlast}, {31'd0, exp_last});
                check_output($sformatf("b_tlast[%0d]", idx), {31'd0, m_axis_b_tlast}, {31'd0, exp_last});
            end
            if (k < n) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = base + 32'(k);
                s_axis_tlast  = (k == tlast_pos);
            end else begin
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge aclk);
            if (frame_done) pulses++;
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        s_axis_tvalid   = 1'b0;
        s_axis_tdata    = '0;
        s_axis_tlast    = 1'b0;
        coef_wr_en      = 1'b0;
        coef_wr_addr    = '0;
        coef_wr_data    = '0;
        m_axis_a_tready = 1'b1;
        m_axis_b_tready = 1'b1;
        aresetn         = 1'b1;
        #2 aresetn      = 1'b0;

        // Load the coefficient table while reset is held.
        for (int i = 0; i < FRAME_LEN; i++) begin
            @(negedge aclk);
            coef_wr_en   = 1'b1;
            coef_wr_addr = IDX_W'(i);
            if (i == 0)      coef_wr_data = 32'h3F80_0000;
            else if (i == 5) coef_wr_data = 32'h3F00_0000;
            else             coef_wr_data = 32'h1000_0000 + 32'(i);
            exp_coef[i] = coef_wr_data;
        end
        @(negedge aclk);
        coef_wr_en = 1'b0;

        // Reset state.
        check_output("rst a_tvalid", {31'd0, m_axis_a_tvalid}, 32'd0);
        check_output("rst b_tvalid", {31'd0, m_axis_b_tvalid}, 32'd0);
        check_output("rst a_tdata", m_axis_a_tdata, 32'd0);
        check_output("rst b_tdata", m_axis_b_tdata, 32'd0);
        check_output("rst tlast", {30'd0, m_axis_a_tlast, m_axis_b_tlast}, 32'd0);
        check_output("rst sample_idx", 32'(sample_idx), 32'd0);
        check_output("rst flags", {30'd0, frame_done, frame_err}, 32'd0);
        check_output("rst s_tready", {31'd0, s_axis_tready}, 32'd0);
        aresetn = 1'b1;

        // First pair: sample with RAM[0].
        @(negedge aclk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h3E9E_377A;
        s_axis_tlast  = 1'b0;
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        check_output("first a_tdata", m_axis_a_tdata, 32'h3E9E_377A);
        check_output("first b_tdata", m_axis_b_tdata, 32'h3F80_0000);
        check_output("first tvalids", {30'd0, m_axis_a_tvalid, m_axis_b_tvalid}, 32'd3);
        check_output("first sample_idx", 32'(sample_idx), 32'd1);
        @(negedge aclk);
        check_output("first drained", {30'd0, m_axis_a_tvalid, m_axis_b_tvalid}, 32'd0);

        // Backpressure on b only: sample 1 offered, sample 2 waits behind it.
        m_axis_b_tready = 1'b0;
        s_axis_tvalid   = 1'b1;
        s_axis_tdata    = 32'hAAAA_0001;
        @(negedge aclk);
        s_axis_tdata = 32'hAAAA_0002;
        #1;
        check_output("bp s_tready n1", {31'd0, s_axis_tready}, 32'd0);
        check_output("bp sample_idx n1", 32'(sample_idx), 32'd2);
        @(negedge aclk);
        check_output("bp valids n2", {30'd0, m_axis_a_tvalid, m_axis_b_tvalid}, 32'd1);
        check_output("bp b_tdata n2", m_axis_b_tdata, exp_coef[1]);
        check_output("bp s_tready n2", {31'd0, s_axis_tready}, 32'd0);
        @(negedge aclk);
        check_output("bp b_tdata n3", m_axis_b_tdata, exp_coef[1]);
        check_output("bp sample_idx n3", 32'(sample_idx), 32'd2);
        check_output("bp a_tdata n3", m_axis_a_tdata, 32'hAAAA_0001);
        m_axis_b_tready = 1'b1;
        #1;
        check_output("bp s_tready release", {31'd0, s_axis_tready}, 32'd1);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        check_output("bp a_tdata next", m_axis_a_tdata, 32'hAAAA_0002);
        check_output("bp b_tdata next", m_axis_b_tdata, exp_coef[2]);
        check_output("bp sample_idx next", 32'(sample_idx), 32'd3);
        @(negedge aclk);
        check_output("bp drained", {30'd0, m_axis_a_tvalid, m_axis_b_tvalid}, 32'd0);

        // Complete the current frame (indices 3..255), then one full frame.
        apply_stimulus(3, 253, 252, 32'h0100_0000, done_cnt);
        check_output("tail frame_done count", 32'(done_cnt), 32'd1);
        check_output("tail sample_idx", 32'(sample_idx), 32'd0);
        apply_stimulus(0, 256, 255, 32'h0200_0000, done_cnt);
        check_output("full frame_done count", 32'(done_cnt), 32'd1);
        check_output("full sample_idx", 32'(sample_idx), 32'd0);
        check_output("full frame_err", {31'd0, frame_err}, 32'd0);

        // Read-first collision on index 5.
        apply_stimulus(0, 5, -1, 32'h0300_0000, done_cnt);
        check_output("pre-col frame_done count", 32'(done_cnt), 32'd0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h0300_0005;
        coef_wr_en    = 1'b1;
        coef_wr_addr  = 8'd5;
        coef_wr_data  = 32'h4000_0000;
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        coef_wr_en    = 1'b0;
        check_output("col b_tdata", m_axis_b_tdata, 32'h3F00_0000);
        check_output("col a_tdata", m_axis_a_tdata, 32'h0300_0005);
        check_output("col sample_idx", 32'(sample_idx), 32'd6);
        exp_coef[5] = 32'h4000_0000;
        apply_stimulus(6, 250, 249, 32'h0400_0000, done_cnt);
        check_output("col frame_done count", 32'(done_cnt), 32'd1);
        apply_stimulus(0, 6, -1, 32'h0500_0000, done_cnt);
        check_output("post-col sample_idx", 32'(sample_idx), 32'd6);

        // Early tlast on sample 99.
        apply_stimulus(6, 94, 93, 32'h0600_0000, done_cnt);
        check_output("early frame_done count", 32'(done_cnt), 32'd1);
        check_output("early sample_idx", 32'(sample_idx), 32'd0);
        check_output("early frame_err", {31'd0, frame_err}, 32'd1);
        apply_stimulus(0, 1, -1, 32'h0700_0000, done_cnt);
        check_output("sticky frame_err", {31'd0, frame_err}, 32'd1);
        check_output("sticky sample_idx", 32'(sample_idx), 32'd1);

        // Reset with a pending pair at index 40.
        apply_stimulus(1, 39, -1, 32'h0800_0000, done_cnt);
        check_output("pre-rst sample_idx", 32'(sample_idx), 32'd40);
        m_axis_a_tready = 1'b0;
        m_axis_b_tready = 1'b0;
        s_axis_tvalid   = 1'b1;
        s_axis_tdata    = 32'h0800_0028;
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        check_output("pend valids", {30'd0, m_axis_a_tvalid, m_axis_b_tvalid}, 32'd3);
        check_output("pend b_tdata", m_axis_b_tdata, exp_coef[40]);
        #2 aresetn = 1'b0;
        #1;
        check_output("midrst valids", {30'd0, m_axis_a_tvalid, m_axis_b_tvalid}, 32'd0);
        check_output("midrst sample_idx", 32'(sample_idx), 32'd0);
        check_output("midrst frame_err", {31'd0, frame_err}, 32'd0);
        check_output("midrst s_tready", {31'd0, s_axis_tready}, 32'd0);
        @(negedge aclk);
        aresetn         = 1'b1;
        m_axis_a_tready = 1'b1;
        m_axis_b_tready = 1'b1;
        apply_stimulus(0, 1, -1, 32'h0900_0000, done_cnt);
        check_output("after-rst sample_idx", 32'(sample_idx), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/window_operand_feeder.md
WINDOW_OPERAND_FEEDER -- requirements
Module: window_operand_feeder

Interface
REQ-001 Parameter FRAME_LEN, 256, number of samples per analysis frame (power of two, 16..1024).
REQ-002 Parameter IDX_W, 8, width of the sample index, equal to log2(FRAME_LEN).
REQ-003 One clock and one reset: reset is asynchronous and active-low; clock is aclk and reset is aresetn, with no other clock or reset.
REQ-004 aclk  input  1  rising-edge clock for all state.
REQ-005 aresetn  input  1  asynchronous active-low reset.
REQ-006 s_axis_tvalid / s_axis_tready / s_axis_tdata / s_axis_tlast  in/out/in/in  1/1/32/1  float32 sample stream from framing.
REQ-007 coef_wr_en / coef_wr_addr / coef_wr_data  input  1/IDX_W/32  window-coefficient RAM write port.
REQ-008 m_axis_a_tvalid / m_axis_a_tready / m_axis_a_tdata / m_axis_a_tlast  out/in/out/out  1/1/32/1  sample operand to mul_float32 port a.
REQ-009 m_axis_b_tvalid / m_axis_b_tready / m_axis_b_tdata / m_axis_b_tlast  out/in/out/out  1/1/32/1  coefficient operand to mul_float32 port b.
REQ-010 sample_idx  output  IDX_W  index of the next sample to be accepted.
REQ-011 frame_done  output  1  one-cycle pulse when the last pair of a frame has been fully consumed.
REQ-012 frame_err  output  1  sticky flag for input tlast mismatch.

Function
REQ-013 Coefficient RAM: FRAME_LEN x 32 bits, written on the rising edge when coef_wr_en=1, writable at any time, not cleared by reset.
REQ-014 Input acceptance: s_axis_tready = (!m_axis_a_tvalid | m_axis_a_tready) & (!m_axis_b_tvalid | m_axis_b_tready), combinational.
REQ-015 On acceptance (s_axis_tvalid & s_axis_tready) at edge N, the following happen at N: a_tdata<=s_axis_tdata; b_tdata<=RAM[sample_idx]; a_tvalid<=1; b_tvalid<=1. Latency is 1 cycle, throughput is 1 pair/cycle.
REQ-016 Each output channel holds tvalid and tdata stable until its own handshake, and clears tvalid independently when it handshakes without a new acceptance in the same cycle.
REQ-017 The a and b channels may be consumed on different cycles; no new sample is accepted until both channels of the current pair are consumed or are completing in the same cycle.
REQ-018 Last-sample flag: last = s_axis_tlast | (sample_idx == FRAME_LEN-1), captured into both m_axis_a_tlast and m_axis_b_tlast with the pair.
REQ-019 sample_idx increments by 1 on each acceptance and returns to 0 on acceptance of a last sample (wrap or early tlast).
REQ-020 frame_err sets to 1 on acceptance when s_axis_tlast differs from (sample_idx == FRAME_LEN-1), and remains 1 until reset.
REQ-021 frame_done pulses high for exactly 1 cycle on the cycle after the later of the two handshakes of a tlast pair; if both handshake in the same cycle, it pulses on the next cycle.
REQ-022 Read/write collision: if a coefficient write targets sample_idx in the same cycle as an acceptance, b_tdata takes the old RAM value (read-first).
REQ-023 With no acceptance, all registers hold; a coefficient write alone changes only the RAM.

Reset
REQ-024 While aresetn=0: m_axis_a_tvalid=m_axis_b_tvalid=0, tdata=0, tlast=0, sample_idx=0, frame_done=0, frame_err=0.
REQ-025 Reset asserted mid-frame or with a pending pair discards that pair and the partial frame; after release, the first accepted sample is index 0.
REQ-026 s_axis_tready is 0 while aresetn=0.

Verification
REQ-027 Load RAM[0]=0x3F800000, send sample 0x3E9E377A with both readies=1 -> one cycle later a_tdata=0x3E9E377A, b_tdata=0x3F800000, both tvalid=1, sample_idx=1.
REQ-028 Hold m_axis_b_tready=0 for 3 cycles while a_tready=1 -> a consumed once; b_tdata held; s_axis_tready=0 until b handshakes; no sample lost or duplicated.
REQ-029 Stream 256 samples with tlast on sample 255 -> a/b tlast=1 only on pair 255; sample_idx wraps to 0; frame_done pulses once; frame_err=0.
REQ-030 Assert s_axis_tlast on sample 99 -> output tlast on pair 99; sample_idx=0; frame_err=1 and sticky.
REQ-031 Write RAM[5]=0x40000000 in the same cycle that sample 5 is accepted (old RAM[5]=0x3F000000) -> b_tdata=0x3F000000; sample 5 of the next frame gets 0x40000000.
REQ-032 Pull aresetn low with a pending pair at index 40 -> tvalids drop immediately and sample_idx=0; after release, the next pair uses RAM[0].
